// File: rtl/pose_n_legs.sv
// Tilt (Rx, Ry) to NUM_LEGS servo angles through one shared MAC, one leg per clock.
// Optional slew limiting of committed angles is enabled by defining POSE_SLEW_LIMIT_EN.
module pose_n_legs #(
    parameter int unsigned               NUM_LEGS = 6,
    parameter int unsigned               IN_W     = 13,
    parameter int unsigned               OUT_W    = 12,
    parameter int unsigned               COEF_W   = 12,
    parameter logic [NUM_LEGS*COEF_W-1:0] CX      = '0,
    parameter logic [NUM_LEGS*COEF_W-1:0] CY      = '0,
    parameter int unsigned               SHIFT    = 8,
    parameter logic [OUT_W-1:0]          CENTER   = OUT_W'(2048),
    parameter int unsigned               MAX_STEP = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      validIn,
    input  logic signed [IN_W-1:0]    Rx,
    input  logic signed [IN_W-1:0]    Ry,
    output logic                      ready,
    output logic                      validOut,
    output logic [NUM_LEGS*OUT_W-1:0] angles
);

    localparam int unsigned LEG_W = (NUM_LEGS > 1) ? $clog2(NUM_LEGS) : 1;
    localparam int unsigned P_W   = IN_W + COEF_W + 1;
    localparam int unsigned A_W   = P_W + 2;
    localparam logic signed [A_W-1:0] MAX_A = A_W'((64'd1 << OUT_W) - 64'd1);

    if (NUM_LEGS < 2 || NUM_LEGS > 16 || MAX_STEP == 0) begin : g_bad_param
        $error("pose_n_legs: NUM_LEGS must be 2..16 and MAX_STEP nonzero");
    end

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, COMMIT} state_t;

    state_t                      state_q, state_d;
    logic [LEG_W-1:0]            leg_q, leg_d;
    logic signed [IN_W-1:0]      rx_q, rx_d, ry_q, ry_d;
    logic signed [P_W-1:0]       p_q, p_d;
    logic                        pv_q, pv_d;
    logic [LEG_W-1:0]            pleg_q, pleg_d;
    logic [OUT_W-1:0]            shadow_q [NUM_LEGS];
    logic [OUT_W-1:0]            shadow_d [NUM_LEGS];
    logic [NUM_LEGS*OUT_W-1:0]   angles_q, angles_d;
    logic                        ready_q, ready_d;
    logic                        valid_q, valid_d;

    logic                        accept_c;
    logic signed [COEF_W-1:0]    cx_sel_c, cy_sel_c;
    logic signed [P_W-1:0]       p_c, d_c;
    logic signed [A_W-1:0]       a_c;
    logic [OUT_W-1:0]            sat_c;
    logic [OUT_W-1:0]            next_c;
`ifdef POSE_SLEW_LIMIT_EN
    localparam int unsigned D_W = OUT_W + 2;
    localparam logic signed [D_W-1:0] STEP = D_W'(MAX_STEP);
    logic signed [D_W-1:0]       diff_c;
`endif

    always_comb begin
        state_d  = state_q;
        leg_d    = leg_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        p_d      = p_q;
        pv_d     = 1'b0;
        pleg_d   = pleg_q;
        shadow_d = shadow_q;
        angles_d = angles_q;
        ready_d  = ready_q;
        valid_d  = 1'b0;
        accept_c = validIn & ready_q;
        cx_sel_c = '0;
        cy_sel_c = '0;
        next_c   = '0;
`ifdef POSE_SLEW_LIMIT_EN
        diff_c   = '0;
`endif

        // Stage 1: coefficient select and product for the current leg
        for (int i = 0; i < NUM_LEGS; i++) begin
            if (leg_q == LEG_W'(i)) begin
                cx_sel_c = CX[i*COEF_W +: COEF_W];
                cy_sel_c = CY[i*COEF_W +: COEF_W];
            end
        end
        p_c = P_W'(cx_sel_c) * P_W'(ry_q) - P_W'(cy_sel_c) * P_W'(rx_q);

        // Stage 2: floor shift, mirror odd legs, offset and saturate into the shadow
        d_c = p_q >>> SHIFT;
        a_c = A_W'(d_c);
        if (pleg_q[0]) a_c = -a_c;
        a_c = a_c + A_W'({1'b0, CENTER});
        if (a_c < 0)          sat_c = '0;
        else if (a_c > MAX_A) sat_c = '1;
        else                  sat_c = OUT_W'(a_c);
        if (pv_q) begin
            for (int i = 0; i < NUM_LEGS; i++) begin
                if (pleg_q == LEG_W'(i)) shadow_d[i] = sat_c;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = CALC;
                    leg_d   = '0;
                    rx_d    = Rx;
                    ry_d    = Ry;
                    ready_d = 1'b0;
                end
            end
            CALC: begin
                p_d    = p_c;
                pv_d   = 1'b1;
                pleg_d = leg_q;
                if (leg_q == LEG_W'(NUM_LEGS - 1)) state_d = DRAIN;
                else                               leg_d   = leg_q + LEG_W'(1);
            end
            DRAIN: begin
                state_d = COMMIT;
                ready_d = 1'b1;
            end
            COMMIT: begin
                valid_d = 1'b1;
                for (int i = 0; i < NUM_LEGS; i++) begin
`ifdef POSE_SLEW_LIMIT_EN
                    diff_c = $signed({2'b00, shadow_q[i]}) - $signed({2'b00, angles_q[i*OUT_W +: OUT_W]});
                    if (diff_c > STEP)       diff_c = STEP;
                    else if (diff_c < -STEP) diff_c = -STEP;
                    next_c = OUT_W'($signed({2'b00, angles_q[i*OUT_W +: OUT_W]}) + diff_c);
`else
                    next_c = shadow_q[i];
`endif
                    angles_d[i*OUT_W +: OUT_W] = next_c;
                end
                if (accept_c) begin
                    state_d = CALC;
                    leg_d   = '0;
                    rx_d    = Rx;
                    ry_d    = Ry;
                    ready_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            leg_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            p_q      <= '0;
            pv_q     <= 1'b0;
            pleg_q   <= '0;
            for (int i = 0; i < NUM_LEGS; i++) shadow_q[i] <= CENTER;
            angles_q <= {NUM_LEGS{CENTER}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            leg_q    <= leg_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            p_q      <= p_d;
            pv_q     <= pv_d;
            pleg_q   <= pleg_d;
            shadow_q <= shadow_d;
            angles_q <= angles_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign ready    = ready_q;
    assign validOut = valid_q;
    assign angles   = angles_q;

endmodule
